// File: rtl/ku_aurora_link_supervisor_if.sv
// Signal bundle between the Aurora bootup controller / core and the link supervisor.
// The slave modport is the supervisor's view; master is the controller/core side.
interface ku_aurora_link_supervisor_if;
  logic        PMA_INIT;
  logic        RESET_PB;
  logic        CHANNEL_UP;
  logic        HARD_ERR;
  logic        SOFT_ERR;
  logic        PMA_INIT_O;
  logic        RESET_PB_O;
  logic        LINK_OK;
  logic        HARD_FAIL;
  logic [2:0]  STATE;
  logic [7:0]  RETRY_CNT;
  logic [7:0]  DROP_CNT;
  logic [15:0] SOFT_ERR_CNT;

  modport slave (
    input  PMA_INIT,
    input  RESET_PB,
    input  CHANNEL_UP,
    input  HARD_ERR,
    input  SOFT_ERR,
    output PMA_INIT_O,
    output RESET_PB_O,
    output LINK_OK,
    output HARD_FAIL,
    output STATE,
    output RETRY_CNT,
    output DROP_CNT,
    output SOFT_ERR_CNT
  );

  modport master (
    output PMA_INIT,
    output RESET_PB,
    output CHANNEL_UP,
    output HARD_ERR,
    output SOFT_ERR,
    input  PMA_INIT_O,
    input  RESET_PB_O,
    input  LINK_OK,
    input  HARD_FAIL,
    input  STATE,
    input  RETRY_CNT,
    input  DROP_CNT,
    input  SOFT_ERR_CNT
  );
endinterface

// File: rtl/ku_aurora_link_supervisor.sv
// Aurora 64b66b link supervisor: watches CHANNEL_UP/HARD_ERR after bootup and re-runs the
// PMA_INIT/RESET_PB sequence on failure, giving up after MAX_RETRY attempts.
module ku_aurora_link_supervisor #(
  parameter int unsigned UP_TIMEOUT    = 500000,
  parameter int unsigned STABLE_CYCLES = 10000,
  parameter int unsigned REINIT_WIDTH  = 128,
  parameter int unsigned MAX_RETRY     = 7,
  parameter int unsigned TMR_W         = 20
) (
  input logic                       CLK100,
  input logic                       RST_N,
  ku_aurora_link_supervisor_if.slave link
);

  typedef enum logic [2:0] {
    StBoot   = 3'd0,
    StWaitUp = 3'd1,
    StStable = 3'd2,
    StUp     = 3'd3,
    StRePma  = 3'd4,
    StRePb   = 3'd5,
    StFail   = 3'd6
  } state_e;

  localparam logic [TMR_W-1:0] UpLast     = TMR_W'(UP_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] StableLast = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] ReLast     = TMR_W'(REINIT_WIDTH - 1);
  localparam logic [7:0]       RetryMax   = 8'(MAX_RETRY);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               pma_q, pma_d;
  logic               pb_q, pb_d;
  logic [7:0]         retry_q, retry_d;
  logic [7:0]         drop_q, drop_d;
  logic [15:0]        soft_q, soft_d;
  logic               reinit;
  logic               ext_boot;

  assign ext_boot = link.PMA_INIT | link.RESET_PB;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    pma_d   = pma_q;
    pb_d    = pb_q;
    retry_d = retry_q;
    drop_d  = drop_q;
    soft_d  = soft_q;
    reinit  = 1'b0;

    if (state_q == StUp && link.SOFT_ERR && soft_q != 16'hFFFF) begin
      soft_d = soft_q + 16'd1;
    end

    unique case (state_q)
      StBoot: begin
        timer_d = '0;
        if (!ext_boot) state_d = StWaitUp;
      end
      StWaitUp: begin
        if (ext_boot) begin
          state_d = StBoot;
        end else if (link.HARD_ERR) begin
          reinit = 1'b1;
        end else if (link.CHANNEL_UP) begin
          state_d = StStable;
        end else if (timer_q == UpLast) begin
          reinit = 1'b1;
        end
      end
      StStable: begin
        if (ext_boot) begin
          state_d = StBoot;
        end else if (link.HARD_ERR || !link.CHANNEL_UP) begin
          reinit = 1'b1;
        end else if (timer_q == StableLast) begin
          state_d = StUp;
          retry_d = '0;
        end
      end
      StUp: begin
        timer_d = '0;
        if (ext_boot) begin
          state_d = StBoot;
        end else if (link.HARD_ERR || !link.CHANNEL_UP) begin
          if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          reinit = 1'b1;
        end
      end
      StRePma: begin
        if (timer_q == ReLast) begin
          state_d = StRePb;
          pma_d   = 1'b0;
        end
      end
      StRePb: begin
        if (timer_q == ReLast) begin
          state_d = StWaitUp;
          pb_d    = 1'b0;
        end
      end
      StFail: begin
        timer_d = '0;
      end
      default: begin
        state_d = StBoot;
        pma_d   = 1'b0;
        pb_d    = 1'b0;
      end
    endcase

    if (reinit) begin
      if (retry_q == RetryMax) begin
        state_d = StFail;
        pma_d   = 1'b0;
        pb_d    = 1'b1;
      end else begin
        retry_d = retry_q + 8'd1;
        state_d = StRePma;
        pma_d   = 1'b1;
        pb_d    = 1'b1;
      end
    end

    // Every state entry restarts the timer.
    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge CLK100 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StBoot;
      timer_q <= '0;
      pma_q   <= 1'b0;
      pb_q    <= 1'b0;
      retry_q <= '0;
      drop_q  <= '0;
      soft_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pma_q   <= pma_d;
      pb_q    <= pb_d;
      retry_q <= retry_d;
      drop_q  <= drop_d;
      soft_q  <= soft_d;
    end
  end

  // The OR with the bootup pins is the only combinational term on the core reset lines.
  assign link.PMA_INIT_O   = link.PMA_INIT | pma_q;
  assign link.RESET_PB_O   = link.RESET_PB | pb_q;
  assign link.LINK_OK      = (state_q == StUp);
  assign link.HARD_FAIL    = (state_q == StFail);
  assign link.STATE        = state_q;
  assign link.RETRY_CNT    = retry_q;
  assign link.DROP_CNT     = drop_q;
  assign link.SOFT_ERR_CNT = soft_q;

endmodule

// File: tb/tb_ku_aurora_link_supervisor.sv
// Directed bench for ku_aurora_link_supervisor with shortened timers.
module tb_ku_aurora_link_supervisor;

  logic CLK100;
  logic RST_N;
  int   checks;
  int   failures;

  ku_aurora_link_supervisor_if link_if ();

  ku_aurora_link_supervisor #(
    .UP_TIMEOUT   (50),
    .STABLE_CYCLES(20),
    .REINIT_WIDTH (8),
    .MAX_RETRY    (2),
    .TMR_W        (8)
  ) dut (
    .CLK100(CLK100),
    .RST_N (RST_N),
    .link  (link_if)
  );

  initial CLK100 = 1'b0;
  always #5 CLK100 = ~CLK100;

  task automatic tick();
    @(posedge CLK100);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    int n;
    n = 0;
    while (link_if.STATE !== st && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (link_if.STATE !== st) begin
      failures++;
      $display("FAIL %s: STATE=%0d required %0d within %0d cycles", name, link_if.STATE, st,
               budget);
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #7;
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    link_if.PMA_INIT   = 1'b1;
    link_if.RESET_PB   = 1'b1;
    link_if.CHANNEL_UP = 1'b0;
    link_if.HARD_ERR   = 1'b0;
    link_if.SOFT_ERR   = 1'b0;
    RST_N = 1'b1;
    #3;
    RST_N = 1'b0;
    #20;
    checks++;
    if (link_if.STATE !== 3'd0 || link_if.RETRY_CNT !== 8'd0 || link_if.DROP_CNT !== 8'd0 ||
        link_if.SOFT_ERR_CNT !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: STATE=%0d RETRY=%0d DROP=%0d SOFT=%0d required all 0",
               link_if.STATE, link_if.RETRY_CNT, link_if.DROP_CNT, link_if.SOFT_ERR_CNT);
    end
    checks++;
    if (link_if.PMA_INIT_O !== 1'b1 || link_if.RESET_PB_O !== 1'b1) begin
      failures++;
      $display("FAIL reset_passthru_hi: PMA_O=%b PB_O=%b required 1 1", link_if.PMA_INIT_O,
               link_if.RESET_PB_O);
    end
    link_if.PMA_INIT = 1'b0;
    link_if.RESET_PB = 1'b0;
    #1;
    checks++;
    if (link_if.PMA_INIT_O !== 1'b0 || link_if.RESET_PB_O !== 1'b0 || link_if.LINK_OK !== 1'b0 ||
        link_if.HARD_FAIL !== 1'b0) begin
      failures++;
      $display("FAIL reset_passthru_lo: PMA_O=%b PB_O=%b LINK_OK=%b HARD_FAIL=%b required 0",
               link_if.PMA_INIT_O, link_if.RESET_PB_O, link_if.LINK_OK, link_if.HARD_FAIL);
    end
    #4;
    RST_N = 1'b1;
  endtask

  task automatic test_link_up();
    int bad;
    tick();
    checks++;
    if (link_if.STATE !== 3'd1) begin
      failures++;
      $display("FAIL boot_to_wait: STATE=%0d required 1", link_if.STATE);
    end
    for (int i = 0; i < 9; i++) tick();
    link_if.CHANNEL_UP = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (link_if.STATE !== 3'd2 || link_if.LINK_OK !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stable_20: %0d of 20 samples not STABLE/LINK_OK=0, required 0", bad);
    end
    checks++;
    if (link_if.STATE !== 3'd3 || link_if.LINK_OK !== 1'b1 || link_if.RETRY_CNT !== 8'd0) begin
      failures++;
      $display("FAIL link_up: STATE=%0d LINK_OK=%b RETRY=%0d required 3 1 0", link_if.STATE,
               link_if.LINK_OK, link_if.RETRY_CNT);
    end
  endtask

  task automatic test_soft_err();
    int bad;
    link_if.SOFT_ERR = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    checks++;
    if (link_if.SOFT_ERR_CNT !== 16'd100) begin
      failures++;
      $display("FAIL soft_100: SOFT_ERR_CNT=%0d required 100", link_if.SOFT_ERR_CNT);
    end
    bad = 0;
    for (int i = 0; i < 69900; i++) begin
      tick();
      if (link_if.LINK_OK !== 1'b1) bad++;
    end
    link_if.SOFT_ERR = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL soft_link_ok: LINK_OK low on %0d cycles, required 0", bad);
    end
    tick();
    checks++;
    if (link_if.SOFT_ERR_CNT !== 16'hFFFF || link_if.STATE !== 3'd3) begin
      failures++;
      $display("FAIL soft_sat: SOFT_ERR_CNT=%h STATE=%0d required ffff 3", link_if.SOFT_ERR_CNT,
               link_if.STATE);
    end
  endtask

  task automatic test_ext_reboot();
    link_if.RESET_PB = 1'b1;
    #1;
    checks++;
    if (link_if.RESET_PB_O !== 1'b1) begin
      failures++;
      $display("FAIL reboot_pb_o_now: RESET_PB_O=%b required 1", link_if.RESET_PB_O);
    end
    tick();
    tick();
    checks++;
    if (link_if.STATE !== 3'd0 || link_if.RESET_PB_O !== 1'b1 || link_if.LINK_OK !== 1'b0) begin
      failures++;
      $display("FAIL reboot_boot: STATE=%0d PB_O=%b LINK_OK=%b required 0 1 0", link_if.STATE,
               link_if.RESET_PB_O, link_if.LINK_OK);
    end
    link_if.RESET_PB = 1'b0;
    tick();
    checks++;
    if (link_if.STATE !== 3'd1 || link_if.DROP_CNT !== 8'd0 || link_if.RETRY_CNT !== 8'd0 ||
        link_if.SOFT_ERR_CNT !== 16'hFFFF || link_if.RESET_PB_O !== 1'b0) begin
      failures++;
      $display("FAIL reboot_counters: STATE=%0d DROP=%0d RETRY=%0d SOFT=%h PB_O=%b req 1 0 0 ffff 0",
               link_if.STATE, link_if.DROP_CNT, link_if.RETRY_CNT, link_if.SOFT_ERR_CNT,
               link_if.RESET_PB_O);
    end
    wait_state(3'd3, 40, "reboot_relink");
  endtask

  task automatic test_drop();
    int bad_pma;
    int bad_pb;
    link_if.CHANNEL_UP = 1'b0;
    link_if.HARD_ERR   = 1'b1;
    tick();
    link_if.HARD_ERR = 1'b0;
    checks++;
    if (link_if.STATE !== 3'd4 || link_if.DROP_CNT !== 8'd1 || link_if.RETRY_CNT !== 8'd1) begin
      failures++;
      $display("FAIL drop_once: STATE=%0d DROP=%0d RETRY=%0d required 4 1 1", link_if.STATE,
               link_if.DROP_CNT, link_if.RETRY_CNT);
    end
    bad_pma = 0;
    for (int i = 0; i < 8; i++) begin
      if (link_if.STATE !== 3'd4 || link_if.PMA_INIT_O !== 1'b1 || link_if.RESET_PB_O !== 1'b1)
        bad_pma++;
      tick();
    end
    bad_pb = 0;
    for (int i = 0; i < 8; i++) begin
      if (link_if.STATE !== 3'd5 || link_if.PMA_INIT_O !== 1'b0 || link_if.RESET_PB_O !== 1'b1)
        bad_pb++;
      tick();
    end
    checks++;
    if (bad_pma != 0 || bad_pb != 0) begin
      failures++;
      $display("FAIL drop_reinit_phases: bad RE_PMA=%0d bad RE_PB=%0d required 0 0", bad_pma,
               bad_pb);
    end
    checks++;
    if (link_if.STATE !== 3'd1 || link_if.RESET_PB_O !== 1'b0 || link_if.PMA_INIT_O !== 1'b0) begin
      failures++;
      $display("FAIL drop_wait: STATE=%0d PB_O=%b PMA_O=%b required 1 0 0", link_if.STATE,
               link_if.RESET_PB_O, link_if.PMA_INIT_O);
    end
    link_if.CHANNEL_UP = 1'b1;
    wait_state(3'd3, 40, "drop_relink");
    checks++;
    if (link_if.RETRY_CNT !== 8'd0 || link_if.DROP_CNT !== 8'd1) begin
      failures++;
      $display("FAIL drop_relink_cnt: RETRY=%0d DROP=%0d required 0 1", link_if.RETRY_CNT,
               link_if.DROP_CNT);
    end
  endtask

  task automatic test_glitch();
    int saw_ok;
    link_if.RESET_PB   = 1'b1;
    link_if.CHANNEL_UP = 1'b0;
    tick();
    link_if.RESET_PB = 1'b0;
    tick();
    tick();
    link_if.CHANNEL_UP = 1'b1;
    tick();
    checks++;
    if (link_if.STATE !== 3'd2) begin
      failures++;
      $display("FAIL glitch_stable: STATE=%0d required 2", link_if.STATE);
    end
    saw_ok = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (link_if.LINK_OK !== 1'b0) saw_ok++;
    end
    link_if.CHANNEL_UP = 1'b0;
    tick();
    checks++;
    if (link_if.STATE !== 3'd4 || link_if.RETRY_CNT !== 8'd1 || link_if.DROP_CNT !== 8'd1) begin
      failures++;
      $display("FAIL glitch_reinit: STATE=%0d RETRY=%0d DROP=%0d required 4 1 1", link_if.STATE,
               link_if.RETRY_CNT, link_if.DROP_CNT);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (link_if.LINK_OK !== 1'b0) saw_ok++;
    end
    checks++;
    if (saw_ok != 0) begin
      failures++;
      $display("FAIL glitch_no_link_ok: LINK_OK high on %0d samples, required 0", saw_ok);
    end
  endtask

  task automatic test_timeout_fail();
    int bad;
    do_reset();
    checks++;
    if (link_if.STATE !== 3'd1 || link_if.RETRY_CNT !== 8'd0 || link_if.DROP_CNT !== 8'd0) begin
      failures++;
      $display("FAIL to_start: STATE=%0d RETRY=%0d DROP=%0d required 1 0 0", link_if.STATE,
               link_if.RETRY_CNT, link_if.DROP_CNT);
    end
    for (int r = 1; r <= 2; r++) begin
      bad = 0;
      for (int i = 0; i < 50; i++) begin
        if (link_if.STATE !== 3'd1) bad++;
        tick();
      end
      for (int i = 0; i < 8; i++) begin
        if (link_if.STATE !== 3'd4 || link_if.PMA_INIT_O !== 1'b1 || link_if.RESET_PB_O !== 1'b1 ||
            link_if.RETRY_CNT !== 8'(r)) bad++;
        tick();
      end
      for (int i = 0; i < 8; i++) begin
        if (link_if.STATE !== 3'd5 || link_if.PMA_INIT_O !== 1'b0 || link_if.RESET_PB_O !== 1'b1)
          bad++;
        tick();
      end
      checks++;
      if (bad != 0 || link_if.STATE !== 3'd1) begin
        failures++;
        $display("FAIL to_attempt%0d: %0d bad samples, end STATE=%0d required 0 bad, STATE 1", r,
                 bad, link_if.STATE);
      end
    end
    for (int i = 0; i < 50; i++) tick();
    checks++;
    if (link_if.STATE !== 3'd6 || link_if.HARD_FAIL !== 1'b1 || link_if.RESET_PB_O !== 1'b1 ||
        link_if.PMA_INIT_O !== 1'b0 || link_if.LINK_OK !== 1'b0) begin
      failures++;
      $display("FAIL to_fail: STATE=%0d HF=%b PB_O=%b PMA_O=%b OK=%b required 6 1 1 0 0",
               link_if.STATE, link_if.HARD_FAIL, link_if.RESET_PB_O, link_if.PMA_INIT_O,
               link_if.LINK_OK);
    end
    bad = 0;
    link_if.CHANNEL_UP = 1'b1;
    for (int i = 0; i < 40; i++) begin
      link_if.PMA_INIT = (i >= 10 && i < 15);
      link_if.HARD_ERR = (i >= 20 && i < 22);
      tick();
      if (link_if.STATE !== 3'd6 || link_if.RESET_PB_O !== 1'b1) bad++;
    end
    link_if.PMA_INIT   = 1'b0;
    link_if.HARD_ERR   = 1'b0;
    link_if.CHANNEL_UP = 1'b0;
    checks++;
    if (bad != 0 || link_if.RETRY_CNT !== 8'd2) begin
      failures++;
      $display("FAIL fail_sticky: %0d bad samples RETRY=%0d required 0 2", bad,
               link_if.RETRY_CNT);
    end
  endtask

  task automatic test_reset_mid_reinit();
    do_reset();
    wait_state(3'd5, 70, "mid_reach_re_pb");
    tick();
    tick();
    link_if.PMA_INIT = 1'b1;
    RST_N = 1'b0;
    #1;
    checks++;
    if (link_if.STATE !== 3'd0 || link_if.PMA_INIT_O !== 1'b1 || link_if.RESET_PB_O !== 1'b0 ||
        link_if.RETRY_CNT !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset: STATE=%0d PMA_O=%b PB_O=%b RETRY=%0d required 0 1 0 0",
               link_if.STATE, link_if.PMA_INIT_O, link_if.RESET_PB_O, link_if.RETRY_CNT);
    end
    link_if.PMA_INIT = 1'b0;
    #1;
    checks++;
    if (link_if.PMA_INIT_O !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_follow: PMA_O=%b required 0", link_if.PMA_INIT_O);
    end
    #5;
    RST_N = 1'b1;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_link_up();
    test_soft_err();
    test_ext_reboot();
    test_drop();
    test_glitch();
    test_timeout_fail();
    test_reset_mid_reinit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ku_aurora_link_supervisor.md
Name: ku_aurora_link_supervisor

Overview:
- Sits directly downstream of the Aurora 64b66b bootup controller, between that controller's PMA_INIT/RESET_PB outputs and the Aurora core reset inputs.
- Watches CHANNEL_UP and HARD_ERR after bootup releases the core.
- If the link fails to come up, drops, or hard-errors, re-runs the reset sequence: RESET_PB high, PMA_INIT pulse, PMA_INIT low, then RESET_PB low.
- Gives up after a bounded number of retries and exports link status and error counters.

Parameters:
UP_TIMEOUT, 500000, cycles to wait in WAIT_UP for CHANNEL_UP (5 ms at 100 MHz)
STABLE_CYCLES, 10000, cycles CHANNEL_UP must stay high before the link is declared up
REINIT_WIDTH, 128, cycles for each of the two reinit phases
MAX_RETRY, 7, reinit attempts allowed before entering FAIL (1..255)
TMR_W, 20, timer width; must hold max(UP_TIMEOUT, STABLE_CYCLES, REINIT_WIDTH)

Ports:
CLK100  in  1  system clock, 100 MHz
RST_N  in  1  asynchronous active-low reset
PMA_INIT  in  1  from bootup controller
RESET_PB  in  1  from bootup controller
CHANNEL_UP  in  1  Aurora channel up, synchronous to CLK100
HARD_ERR  in  1  Aurora hard error, synchronous
SOFT_ERR  in  1  Aurora soft error, synchronous, one count per high cycle
PMA_INIT_O  out  1  to Aurora core: PMA_INIT | pma_reg
RESET_PB_O  out  1  to Aurora core: RESET_PB | pb_reg
LINK_OK  out  1  high only in state UP
HARD_FAIL  out  1  high only in state FAIL
STATE  out  3  BOOT=0, WAIT_UP=1, STABLE=2, UP=3, RE_PMA=4, RE_PB=5, FAIL=6
RETRY_CNT  out  8  reinit attempts since last UP
DROP_CNT  out  8  saturating count of exits from UP
SOFT_ERR_CNT  out  16  saturating soft-error count, counts only in UP

Behaviour:
- Reset (RST_N low, async):
  - State is BOOT; timer, pma_reg, pb_reg and all counters are 0.
  - PMA_INIT_O and RESET_PB_O therefore pass the input pins straight through.
- All state, timer and counter updates are registered on CLK100. LINK_OK, HARD_FAIL and STATE decode the state register.
- Timer clears on every state entry and increments by 1 each cycle in a timed state.
- BOOT: when PMA_INIT=0 and RESET_PB=0 -> WAIT_UP.
- WAIT_UP:
  - CHANNEL_UP=1 -> STABLE, even on the first cycle of the state.
  - Otherwise, on the UP_TIMEOUT-th cycle -> reinit request.
- STABLE:
  - CHANNEL_UP=0 -> reinit request.
  - Otherwise, on the STABLE_CYCLES-th cycle -> UP, and RETRY_CNT clears to 0.
- HARD_ERR=1 in WAIT_UP or STABLE -> reinit request. HARD_ERR has priority over the timers.
- UP:
  - CHANNEL_UP=0 or HARD_ERR=1 -> DROP_CNT+1 (saturating at 255), then reinit request.
  - Both in the same cycle count as one drop.
- Reinit request:
  - If RETRY_CNT==MAX_RETRY -> FAIL.
  - Else RETRY_CNT+1 -> RE_PMA.
- RE_PMA:
  - pma_reg=1 and pb_reg=1 for REINIT_WIDTH cycles -> RE_PB.
- RE_PB:
  - pma_reg=0, pb_reg=1 for REINIT_WIDTH cycles -> WAIT_UP.
  - pb_reg clears on the cycle WAIT_UP is entered.
- FAIL:
  - Sticky until RST_N.
  - pb_reg=1 and pma_reg=0, so the core is held in reset.
  - Inputs are ignored.
- External reboot: PMA_INIT=1 or RESET_PB=1 in WAIT_UP, STABLE or UP -> BOOT.
  - No counter changes.
  - Takes priority over all other transitions in those states.
  - Ignored in RE_PMA, RE_PB and FAIL.
- SOFT_ERR_CNT increments each cycle with SOFT_ERR=1 while in UP, and saturates at 0xFFFF.
- No output glitch:
  - pma_reg and pb_reg are flops.
  - The output OR is the only combinational term.
- Reset mid-reinit returns immediately to pass-through and BOOT.

Test Plan:
- Params UP_TIMEOUT=50, STABLE_CYCLES=20, REINIT_WIDTH=8, MAX_RETRY=2.
  - Inputs low, CHANNEL_UP rises 10 cycles after WAIT_UP entry.
  - Required: STABLE 20 cycles, then LINK_OK=1, STATE=3, RETRY_CNT=0.
- CHANNEL_UP held 0:
  - WAIT_UP lasts 50 cycles.
  - RE_PMA: PMA_INIT_O=1 and RESET_PB_O=1 for 8 cycles.
  - RE_PB: PMA_INIT_O=0, RESET_PB_O=1 for 8 cycles.
  - Sequence repeats with RETRY_CNT=1, then 2.
  - Third timeout -> STATE=6, HARD_FAIL=1, RESET_PB_O=1 permanently.
- Link UP, CHANNEL_UP and HARD_ERR drop/rise in the same cycle:
  - DROP_CNT=1, RETRY_CNT=1, STATE=4 next cycle.
  - After reinit and CHANNEL_UP=1, returns to UP with RETRY_CNT=0.
- CHANNEL_UP glitches low at STABLE cycle 15:
  - Reinit request; LINK_OK never asserts.
- In UP, SOFT_ERR high for 70000 cycles:
  - SOFT_ERR_CNT=0xFFFF, LINK_OK stays 1.
- Two further cases:
  - RESET_PB input pulses 1 in UP -> STATE=0 and RESET_PB_O=1 while the pulse lasts; counters unchanged.
  - RST_N low during RE_PB -> outputs follow inputs immediately, STATE=0.
